// File: rtl/counter_seq_ctrl_if.sv
// Command/status and counter-control signals between the sequencer (slave) and its environment (master).
interface counter_seq_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_target;
    logic [7:0]       cfg_hold;
    logic [REP_W-1:0] cfg_repeat;
    logic [CNT_W-1:0] cnt_count;
    logic             cnt_overflow;
    logic             cnt_enable;
    logic             cnt_up_down;
    logic             busy;
    logic             done;
    logic             err;
    logic [REP_W-1:0] pass_cnt;

    modport master (
        output start, abort, cfg_target, cfg_hold, cfg_repeat, cnt_count, cnt_overflow,
        input  cnt_enable, cnt_up_down, busy, done, err, pass_cnt
    );

    modport slave (
        input  start, abort, cfg_target, cfg_hold, cfg_repeat, cnt_count, cnt_overflow,
        output cnt_enable, cnt_up_down, busy, done, err, pass_cnt
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sweep sequencer for the up/down counter: up T steps, hold H cycles, down T steps, R+1 passes.
// Optional macro COUNTER_SEQ_CHECK_EN adds trajectory and overflow checking of the counter.
module counter_seq_ctrl #(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    counter_seq_ctrl_if.slave bus
);
    localparam int                STEP_W   = (CNT_W > 8) ? CNT_W : 8;
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [REP_W-1:0]  PASS_ONE = REP_W'(1);

    typedef enum logic [2:0] {IDLE, UP, HOLD, DOWN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  target_q;
    logic [7:0]        hold_q;
    logic [REP_W-1:0]  repeat_q, pass_q;
    logic [STEP_W-1:0] step_q;
    logic              err_q, enable_q, up_down_q, busy_q, done_q;

    logic [CNT_W:0]    reach;
    logic              over_range, in_run, abort_hit, last_step, last_hold;
    logic              accept, reject, step_clr, pass_inc, leave_up;
    logic              check_fail;

    // Rejection looks at the live count, one bit wider so a wrap past all-ones is visible.
    assign reach      = {1'b0, bus.cnt_count} + {1'b0, bus.cfg_target};
    assign over_range = reach[CNT_W];
    assign in_run     = (state_q == UP) || (state_q == HOLD) || (state_q == DOWN);
    assign abort_hit  = bus.abort && in_run;
    assign last_step  = (step_q + STEP_ONE) == STEP_W'(target_q);
    assign last_hold  = (step_q + STEP_ONE) == STEP_W'(hold_q);

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        reject   = 1'b0;
        step_clr = 1'b0;
        pass_inc = 1'b0;
        leave_up = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    step_clr = 1'b1;
                    if (over_range) begin
                        reject  = 1'b1;
                        state_d = DONE;
                    end else if (bus.cfg_target == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = UP;
                    end
                end
            end
            UP: begin
                if (last_step) begin
                    step_clr = 1'b1;
                    leave_up = 1'b1;
                    state_d  = (hold_q != 8'd0) ? HOLD : DOWN;
                end
            end
            HOLD: begin
                if (last_hold) begin
                    step_clr = 1'b1;
                    state_d  = DOWN;
                end
            end
            DOWN: begin
                if (last_step) begin
                    step_clr = 1'b1;
                    pass_inc = 1'b1;
                    state_d  = (pass_q == repeat_q) ? DONE : UP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort leaves pass count and error untouched and suppresses any pending check.
        if (abort_hit) begin
            state_d  = DONE;
            step_clr = 1'b1;
            pass_inc = 1'b0;
            leave_up = 1'b0;
        end
    end

`ifdef COUNTER_SEQ_CHECK_EN
    logic [CNT_W-1:0] base_q;
    logic             chk_up_q, chk_dn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            chk_up_q <= 1'b0;
            chk_dn_q <= 1'b0;
        end else begin
            if (accept) base_q <= bus.cnt_count;
            chk_up_q <= leave_up;
            chk_dn_q <= pass_inc;
        end
    end

    assign check_fail = (chk_up_q && (bus.cnt_count != (base_q + target_q)))
                     || (chk_dn_q && (bus.cnt_count != base_q))
                     || (busy_q && bus.cnt_overflow);
`else
    logic unused_chk;
    assign unused_chk = bus.cnt_overflow | leave_up;
    assign check_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            hold_q    <= '0;
            repeat_q  <= '0;
            pass_q    <= '0;
            step_q    <= '0;
            err_q     <= 1'b0;
            enable_q  <= 1'b0;
            up_down_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                target_q <= bus.cfg_target;
                hold_q   <= bus.cfg_hold;
                repeat_q <= bus.cfg_repeat;
            end
            if (step_clr)    step_q <= '0;
            else if (in_run) step_q <= step_q + STEP_ONE;
            if (accept)        pass_q <= '0;
            else if (pass_inc) pass_q <= pass_q + PASS_ONE;
            if (accept)          err_q <= reject;
            else if (check_fail) err_q <= 1'b1;
            // Outputs are registered from the next state so they line up with state_q.
            enable_q <= (state_d == UP) || (state_d == DOWN);
            if (state_d == UP)        up_down_q <= 1'b1;
            else if (state_d == DOWN) up_down_q <= 1'b0;
            busy_q <= (state_d == UP) || (state_d == HOLD) || (state_d == DOWN);
            done_q <= (state_d == DONE);
        end
    end

    assign bus.cnt_enable  = enable_q;
    assign bus.cnt_up_down = up_down_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.pass_cnt    = pass_q;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl with a behavioural 8-bit up/down counter attached.
// Vector table feeds a scoreboard queue; hand sequences cover abort, reset and start corner cases.
module tb_counter_seq_ctrl;
    localparam int CNT_W = 8;
    localparam int REP_W = 4;
    localparam int MAX_WAIT = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    counter_seq_ctrl_if #(.CNT_W(CNT_W), .REP_W(REP_W)) bus ();

    counter_seq_ctrl #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Counter model: not reset by rst_n, so it keeps its value across a sequencer reset.
    logic [7:0] cnt_model = 8'h00;
    logic       ovf_model = 1'b0;
    logic       ld_en     = 1'b0;
    logic [7:0] ld_val    = 8'h00;

    always @(posedge clk) begin
        if (ld_en) begin
            cnt_model <= ld_val;
            ovf_model <= 1'b0;
        end else if (bus.cnt_enable) begin
            ovf_model <= bus.cnt_up_down ? (cnt_model == 8'hFF) : (cnt_model == 8'h00);
            cnt_model <= bus.cnt_up_down ? cnt_model + 8'd1 : cnt_model - 8'd1;
        end else begin
            ovf_model <= 1'b0;
        end
    end

    assign bus.cnt_count    = cnt_model;
    assign bus.cnt_overflow = ovf_model;

    typedef struct {
        logic [7:0] base;
        logic [7:0] target;
        logic [7:0] hold;
        logic [3:0] rep;
        int         exp_err;
        int         exp_pass;
        int         exp_busy;
        int         exp_en;
        int         exp_lat;
        int         exp_peak;
        int         exp_final;
    } vec_t;

    typedef struct {
        int lat;
        int busy;
        int en;
        int peak;
        int fin;
        int err;
        int pass;
        int done_after;
    } meas_t;

    vec_t vecs[9];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic [7:0] base, input logic [7:0] target, input logic [7:0] hold,
                                input logic [3:0] rep, input int e_err, input int e_pass, input int e_busy,
                                input int e_en, input int e_lat, input int e_peak, input int e_fin);
        vec_t v;
        v.base = base; v.target = target; v.hold = hold; v.rep = rep;
        v.exp_err = e_err; v.exp_pass = e_pass; v.exp_busy = e_busy; v.exp_en = e_en;
        v.exp_lat = e_lat; v.exp_peak = e_peak; v.exp_final = e_fin;
        return v;
    endfunction

    task automatic checkValue(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic startRun(input logic [7:0] base, input logic [7:0] target, input logic [7:0] hold,
                            input logic [3:0] rep, input logic with_abort);
        @(negedge clk);
        ld_en  = 1'b1;
        ld_val = base;
        @(negedge clk);
        ld_en          = 1'b0;
        bus.cfg_target = target;
        bus.cfg_hold   = hold;
        bus.cfg_repeat = rep;
        bus.start      = 1'b1;
        bus.abort      = with_abort;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_q.push_back(v);
        startRun(v.base, v.target, v.hold, v.rep, 1'b0);
    endtask

    task automatic collectRun(output meas_t m);
        m.lat = -1; m.busy = 0; m.en = 0; m.peak = int'(cnt_model);
        m.fin = -1; m.err = -1; m.pass = -1; m.done_after = -1;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            @(negedge clk);
            if (bus.busy) m.busy++;
            if (bus.cnt_enable) m.en++;
            if (int'(cnt_model) > m.peak) m.peak = int'(cnt_model);
            if (bus.done) begin
                m.lat  = i;
                m.fin  = int'(cnt_model);
                m.err  = int'(bus.err);
                m.pass = int'(bus.pass_cnt);
                break;
            end
        end
        @(negedge clk);
        m.done_after = int'(bus.done);
    endtask

    task automatic checkOutput(input int idx, input meas_t m);
        vec_t v;
        if (exp_q.size() == 0) begin
            checkValue($sformatf("v%0d_scoreboard_empty", idx), 0, 1);
            return;
        end
        v = exp_q.pop_front();
        checkValue($sformatf("v%0d_done_latency", idx), m.lat, v.exp_lat);
        checkValue($sformatf("v%0d_busy_cycles", idx), m.busy, v.exp_busy);
        checkValue($sformatf("v%0d_enable_cycles", idx), m.en, v.exp_en);
        checkValue($sformatf("v%0d_peak_count", idx), m.peak, v.exp_peak);
        checkValue($sformatf("v%0d_final_count", idx), m.fin, v.exp_final);
        checkValue($sformatf("v%0d_err", idx), m.err, v.exp_err);
        checkValue($sformatf("v%0d_pass_cnt", idx), m.pass, v.exp_pass);
        checkValue($sformatf("v%0d_done_one_cycle", idx), m.done_after, 0);
    endtask

    task automatic waitDone(input string name, input int exp_lat, input int already);
        int lat;
        lat = -1;
        for (int i = already + 1; i <= MAX_WAIT; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        checkValue(name, lat, exp_lat);
    endtask

    initial begin
        meas_t m;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.cfg_target = '0; bus.cfg_hold = '0; bus.cfg_repeat = '0;

        //            base   T      H      R     err pass busy en  lat peak   final
        vecs[0] = mk(8'h00, 8'd5,  8'd3, 4'd0, 0,  1,   13,  10, 14, 8'h05, 8'h00);
        vecs[1] = mk(8'h10, 8'd2,  8'd0, 4'd2, 0,  3,   12,  12, 13, 8'h12, 8'h10);
        vecs[2] = mk(8'hFC, 8'd5,  8'd2, 4'd0, 1,  0,   0,   0,  1,  8'hFC, 8'hFC);
        vecs[3] = mk(8'h40, 8'd0,  8'd4, 4'd1, 0,  0,   0,   0,  1,  8'h40, 8'h40);
        vecs[4] = mk(8'hF0, 8'd15, 8'd1, 4'd0, 0,  1,   31,  30, 32, 8'hFF, 8'hF0);
        vecs[5] = mk(8'h01, 8'd1,  8'd0, 4'd0, 0,  1,   2,   2,  3,  8'h02, 8'h01);
        vecs[6] = mk(8'h20, 8'd3,  8'd2, 4'd1, 0,  2,   16,  12, 17, 8'h23, 8'h20);
        vecs[7] = mk(8'hFF, 8'd1,  8'd0, 4'd0, 1,  0,   0,   0,  1,  8'hFF, 8'hFF);
        vecs[8] = mk(8'h03, 8'd2,  8'd1, 4'd0, 0,  1,   5,   4,  6,  8'h05, 8'h03);

        // Reset state, both while held and after release.
        repeat (3) @(negedge clk);
        checkValue("reset_held_outputs",
                   int'({bus.cnt_enable, bus.cnt_up_down, bus.busy, bus.done, bus.err, bus.pass_cnt}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("reset_released_outputs",
                   int'({bus.cnt_enable, bus.cnt_up_down, bus.busy, bus.done, bus.err, bus.pass_cnt}), 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            collectRun(m);
            checkOutput(i, m);
        end

        // Abort in IDLE is ignored.
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        checkValue("idle_abort_busy_done", int'({bus.busy, bus.done}), 0);
        bus.abort = 1'b0;

        // Abort in the third UP cycle of a T=10 run.
        startRun(8'h30, 8'd10, 8'd2, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checkValue("abort_done", int'(bus.done), 1);
        checkValue("abort_enable", int'(bus.cnt_enable), 0);
        checkValue("abort_busy", int'(bus.busy), 0);
        checkValue("abort_count", int'(cnt_model), 8'h33);
        checkValue("abort_err_pass", int'({bus.err, bus.pass_cnt}), 0);
        @(negedge clk);
        checkValue("abort_after_done", int'({bus.done, bus.busy}), 0);

        // Simultaneous start and abort in IDLE: start wins.
        startRun(8'h50, 8'd1, 8'd0, 4'd0, 1'b1);
        checkValue("start_abort_enable_updown_busy", int'({bus.cnt_enable, bus.cnt_up_down, bus.busy}), 7);
        bus.abort = 1'b0;
        waitDone("start_abort_done_latency", 3, 0);
        checkValue("start_abort_pass", int'(bus.pass_cnt), 1);

        // Start while busy is ignored.
        startRun(8'h60, 8'd2, 8'd0, 4'd0, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone("busy_start_done_latency", 5, 3);
        checkValue("busy_start_pass", int'(bus.pass_cnt), 1);
        @(negedge clk);
        checkValue("busy_start_no_restart", int'(bus.busy), 0);

        // Asynchronous reset in the middle of HOLD.
        startRun(8'h00, 8'd3, 8'd4, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        checkValue("hold_state_busy_en_ud", int'({bus.busy, bus.cnt_enable, bus.cnt_up_down}), 5);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("async_reset_outputs",
                   int'({bus.cnt_enable, bus.cnt_up_down, bus.busy, bus.done, bus.err, bus.pass_cnt}), 0);
        checkValue("async_reset_count_kept", int'(cnt_model), 8'h03);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(vecs[8]);
        collectRun(m);
        checkOutput(8, m);

`ifdef COUNTER_SEQ_CHECK_EN
        // Counter disturbed during HOLD: err rises after DOWN, run still completes.
        startRun(8'h00, 8'd4, 8'd3, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        ld_en  = 1'b1;
        ld_val = 8'h09;
        @(negedge clk);
        ld_en = 1'b0;
        waitDone("check_done_latency", 12, 6);
        @(negedge clk);
        checkValue("check_err_set", int'(bus.err), 1);
        checkValue("check_count_after", int'(cnt_model), 8'h05);
`endif

        checkValue("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencer for the 8-bit up/down counter (`counter_8bit`). On a start pulse it runs a programmed sweep profile: count up T steps, hold H cycles, count down T steps, repeated R+1 times. It drives the counter's `enable`/`up_down` controls and checks the counter's `count`/`overflow` against the expected trajectory. It sits between the register/command interface and the counter instance, and is the only driver of the counter's controls.

## Interface
- `CNT_W`, 8: counter width; matches the counter's `count` width.
- `REP_W`, 4: width of the repeat field and of `pass_cnt`.
- `clk` input 1: system clock; all logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request; accepted only in IDLE.
- `abort` input 1: terminates a run; highest priority.
- `cfg_target` input CNT_W: steps per up/down phase (T).
- `cfg_hold` input 8: hold cycles between the up and down phases (H).
- `cfg_repeat` input REP_W: extra passes (R); total passes = R+1.
- `cnt_count` input CNT_W: counter's `count`.
- `cnt_overflow` input 1: counter's `overflow`.
- `cnt_enable` output 1: registered; drives the counter's `enable`.
- `cnt_up_down` output 1: registered; drives the counter's `up_down` (1 = up).
- `busy` output 1: high from the cycle after start is accepted until DONE.
- `done` output 1: one-cycle pulse at the end of any run (normal, rejected, aborted).
- `err` output 1: sticky fault flag; cleared when the next start is accepted.
- `pass_cnt` output REP_W: number of completed passes in the current or last run.

## Operation
- States: IDLE, UP, HOLD, DOWN, DONE.
- Start handling: `start` in IDLE latches `cfg_*`, snapshots `base = cnt_count`, clears `err` and `pass_cnt`.
- Rejected start: if `base + T > 2^CNT_W - 1`, the run is rejected. The FSM goes straight to DONE with `err = 1` and never asserts `cnt_enable`.
- Zero target: T = 0 goes straight to DONE with `err = 0`.
- IDLE → UP: `cnt_enable = 1`, `cnt_up_down = 1`. An internal step counter counts T enabled cycles.
- UP exit: after T cycles, go to HOLD if H > 0 (`cnt_enable = 0`), else go directly to DOWN.
- HOLD: lasts exactly H cycles, then goes to DOWN with `cnt_enable = 1`, `cnt_up_down = 0`, for T cycles.
- DOWN exit: after T cycles, `pass_cnt` increments. If `pass_cnt` now equals R+1, go to DONE; else go to UP.
- DONE: lasts one cycle with `done = 1`, `busy = 0`, `cnt_enable = 0`, then returns to IDLE.
- Abort: `abort` in any busy state forces DONE at the next edge and drops `cnt_enable`. `err` and `pass_cnt` are unchanged. `abort` in IDLE is ignored.
- Start while busy is ignored. Simultaneous `start` and `abort` in IDLE: start wins.
- `cnt_up_down` holds its last value whenever `cnt_enable = 0`.

## Timing
- Reset values: state IDLE; `cnt_enable = 0`, `cnt_up_down = 0`, `busy = 0`, `done = 0`, `err = 0`, `pass_cnt = 0`.
- Start latency: start sampled at edge k gives `cnt_enable = 1` after edge k, so the first counter increment lands at edge k+1.
- Step count per phase: exactly T counter edges see `cnt_enable = 1`.
- Pass length: one pass lasts 2T + H cycles.
- Run length: the run lasts (R+1)(2T+H) busy cycles, then one DONE cycle.
- Reset mid-run: all outputs return to reset values immediately. The counter is left at whatever value it has reached.

## Configuration
- `COUNTER_SEQ_CHECK_EN` defined: trajectory checking is active.
  - In the first cycle after leaving UP, `cnt_count` must equal base+T.
  - In the first cycle after leaving DOWN, `cnt_count` must equal base.
  - Any mismatch sets `err`.
  - `cnt_overflow = 1` in any busy cycle sets `err`.
  - Checking never stops the run.
- `COUNTER_SEQ_CHECK_EN` undefined: trajectory and overflow checks are removed, and `cnt_overflow` is unused. `err` is set only by rejected starts.

## Test plan
- Basic pass: base 0x00, T=5, H=3, R=0 → `cnt_count` rises 0x00→0x05, holds 3 cycles, falls to 0x00. `done` pulses on cycle 14 after start; `pass_cnt = 1`; `err = 0`.
- Repeats, no hold: base 0x10, T=2, H=0, R=2 → three passes of 0x10→0x12→0x10, 12 busy cycles; `pass_cnt = 3`.
- Wrap rejection: base 0xFC, T=5 → no `cnt_enable` assertion, DONE next cycle, `err = 1`, `cnt_count` stays 0xFC.
- Abort: `abort` in the third UP cycle of T=10 → `cnt_enable = 0` at the next edge, `done` pulses, `cnt_count = base+3`.
- Async reset: deassert `rst_n` mid-HOLD → all outputs return to 0 without a clock edge. A subsequent start runs normally.
- Check (macro on): counter force-loaded to a wrong value during HOLD → `err = 1` after DOWN. The run still completes with a `done` pulse.
